// File: rtl/skid_slice_pkg.sv
// Shared types for the decoupled skid slice: occupancy-encoded state and count width.
package skid_slice_pkg;

    localparam int unsigned SKID_CNT_W = 2;

    // Encoding doubles as the occupancy count driven on io_count.
    typedef enum logic [SKID_CNT_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/decoupled_skid_slice.sv
// Two-entry registered skid buffer on a ready/valid channel; cuts both the
// valid/data path and the ready path while sustaining one beat per cycle.
module decoupled_skid_slice
    import skid_slice_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_enq_valid,
    output logic                  io_enq_ready,
    input  logic [WIDTH-1:0]      io_enq_bits,
    output logic                  io_deq_valid,
    input  logic                  io_deq_ready,
    output logic [WIDTH-1:0]      io_deq_bits,
    input  logic                  io_flush,
    output logic [SKID_CNT_W-1:0] io_count
);

    skid_state_e      r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    skid_state_e      w_state_nxt;
    logic             w_enq_fire;
    logic             w_deq_fire;
    logic             w_load_main_enq;
    logic             w_load_main_skid;
    logic             w_load_skid;

    // Ready looks only at state and flush, never at io_deq_ready.
    assign io_enq_ready = (r_state != FULL) & ~io_flush;
    assign w_enq_fire   = io_enq_valid & io_enq_ready;
    assign w_deq_fire   = r_valid & io_deq_ready;

    assign io_deq_valid = r_valid;
    assign io_deq_bits  = r_main;
    assign io_count     = r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != EMPTY);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_enq  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (io_flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_enq_fire) begin
                        w_state_nxt     = ONE;
                        w_load_main_enq = 1'b1;
                    end
                end
                ONE: begin
                    if (w_enq_fire && w_deq_fire) begin
                        w_load_main_enq = 1'b1;
                    end else if (w_enq_fire) begin
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end else if (w_deq_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_deq_fire) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // Payload flops are not cleared on dequeue; head keeps the last written value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_enq) begin
                r_main <= io_enq_bits;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= io_enq_bits;
            end
        end
    end

endmodule

// File: tb/tb_decoupled_skid_slice.sv
// Directed self-checking bench for decoupled_skid_slice.
module tb_decoupled_skid_slice;
    import skid_slice_pkg::*;

    logic       clock;
    logic       reset;
    logic       io_enq_valid;
    logic       io_enq_ready;
    logic [2:0] io_enq_bits;
    logic       io_deq_valid;
    logic       io_deq_ready;
    logic [2:0] io_deq_bits;
    logic       io_flush;
    logic [1:0] io_count;

    int total = 0;
    int bad   = 0;

    decoupled_skid_slice #(.WIDTH(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_valid (io_enq_valid),
        .io_enq_ready (io_enq_ready),
        .io_enq_bits  (io_enq_bits),
        .io_deq_valid (io_deq_valid),
        .io_deq_ready (io_deq_ready),
        .io_deq_bits  (io_deq_bits),
        .io_flush     (io_flush),
        .io_count     (io_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; io_enq_valid = 1'b0; io_enq_bits = 3'd0;
        io_deq_ready = 1'b0; io_flush = 1'b0;
        tick; tick;
        reset = 1'b0;
        tick;
        total++; if (io_enq_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", io_enq_ready); end
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", io_deq_valid); end
        total++; if (io_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", io_count); end
        total++; if (io_deq_bits !== 3'd0) begin bad++; $display("FAIL reset_bits got=%0d want=0", io_deq_bits); end
    endtask

    task automatic test_streaming;
        io_deq_ready = 1'b1;
        for (int v = 1; v <= 7; v++) begin
            io_enq_valid = 1'b1; io_enq_bits = 3'(v);
            #1;
            total++; if (io_enq_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", v, io_enq_ready); end
            tick;
            total++; if (io_deq_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", v, io_deq_valid); end
            total++; if (io_deq_bits !== 3'(v)) begin bad++; $display("FAIL stream_bits[%0d] got=%0d want=%0d", v, io_deq_bits, v); end
            total++; if (io_count !== 2'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d want=1", v, io_count); end
        end
        io_enq_valid = 1'b0;
        tick;
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%b want=0", io_deq_valid); end
        total++; if (io_count !== 2'd0) begin bad++; $display("FAIL stream_drain_count got=%0d want=0", io_count); end
    endtask

    task automatic test_backpressure;
        io_deq_ready = 1'b0;
        io_enq_valid = 1'b1; io_enq_bits = 3'h5; tick;
        io_enq_bits = 3'h6; tick;
        io_enq_bits = 3'h7; #1;
        total++; if (io_enq_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", io_enq_ready); end
        tick;
        total++; if (io_count !== 2'd2) begin bad++; $display("FAIL bp_count got=%0d want=2", io_count); end
        total++; if (io_deq_bits !== 3'h5) begin bad++; $display("FAIL bp_head_held got=%0d want=5", io_deq_bits); end
        total++; if (io_deq_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", io_deq_valid); end
        io_deq_ready = 1'b1;
        #1;
        total++; if (io_enq_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_indep got=%b want=0", io_enq_ready); end
        tick;
        total++; if (io_deq_bits !== 3'h6) begin bad++; $display("FAIL bp_second got=%0d want=6", io_deq_bits); end
        total++; if (io_count !== 2'd1) begin bad++; $display("FAIL bp_count_one got=%0d want=1", io_count); end
        total++; if (io_enq_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", io_enq_ready); end
        tick;
        total++; if (io_deq_bits !== 3'h7) begin bad++; $display("FAIL bp_third got=%0d want=7", io_deq_bits); end
        io_enq_valid = 1'b0;
        tick;
        total++; if (io_count !== 2'd0) begin bad++; $display("FAIL bp_drain got=%0d want=0", io_count); end
    endtask

    task automatic test_simultaneous;
        io_deq_ready = 1'b0;
        io_enq_valid = 1'b1; io_enq_bits = 3'h2; tick;
        total++; if (io_deq_bits !== 3'h2) begin bad++; $display("FAIL sim_hold got=%0d want=2", io_deq_bits); end
        io_enq_bits = 3'h3; io_deq_ready = 1'b1; tick;
        total++; if (io_deq_bits !== 3'h3) begin bad++; $display("FAIL sim_bits got=%0d want=3", io_deq_bits); end
        total++; if (io_count !== 2'd1) begin bad++; $display("FAIL sim_count got=%0d want=1", io_count); end
        io_enq_valid = 1'b0; tick;
        total++; if (io_count !== 2'd0) begin bad++; $display("FAIL sim_drain got=%0d want=0", io_count); end
    endtask

    task automatic test_flush;
        io_deq_ready = 1'b0;
        io_enq_valid = 1'b1; io_enq_bits = 3'h4; tick;
        io_enq_bits = 3'h5; tick;
        total++; if (io_count !== 2'd2) begin bad++; $display("FAIL flush_prefill got=%0d want=2", io_count); end
        io_enq_bits = 3'h6; io_flush = 1'b1; #1;
        total++; if (io_enq_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", io_enq_ready); end
        tick;
        io_flush = 1'b0; io_enq_valid = 1'b0; #1;
        total++; if (io_count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", io_count); end
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", io_deq_valid); end
        total++; if (io_deq_bits !== 3'h4) begin bad++; $display("FAIL flush_bits_keep got=%0d want=4", io_deq_bits); end
        io_deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL flush_no_leak[%0d] got=%b want=0", i, io_deq_valid); end
        end
    endtask

    task automatic test_async_reset;
        io_deq_ready = 1'b0;
        io_enq_valid = 1'b1; io_enq_bits = 3'h1; tick;
        io_enq_bits = 3'h2; tick;
        io_enq_valid = 1'b0;
        total++; if (io_count !== 2'd2) begin bad++; $display("FAIL arst_prefill got=%0d want=2", io_count); end
        #2 reset = 1'b1;
        #1;
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", io_deq_valid); end
        total++; if (io_count !== 2'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", io_count); end
        total++; if (io_deq_bits !== 3'd0) begin bad++; $display("FAIL arst_bits got=%0d want=0", io_deq_bits); end
        total++; if (io_enq_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", io_enq_ready); end
        #1 reset = 1'b0;
        tick;
        io_enq_valid = 1'b1; io_enq_bits = 3'h3; io_deq_ready = 1'b1; tick;
        total++; if (io_deq_bits !== 3'h3) begin bad++; $display("FAIL arst_after_bits got=%0d want=3", io_deq_bits); end
        total++; if (io_deq_valid !== 1'b1) begin bad++; $display("FAIL arst_after_valid got=%b want=1", io_deq_valid); end
        io_enq_valid = 1'b0; tick;
        total++; if (io_count !== 2'd0) begin bad++; $display("FAIL arst_drain got=%0d want=0", io_count); end
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_backpressure;
        test_simultaneous;
        test_flush;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
